// File: rtl/histo_readout.sv
// histo_readout: readout sequencer for the 10-bit pixel histogram.
// When start is seen, it takes the histogram out of accumulate mode and
// reads every bin, honouring the fixed memory read latency. It streams a
// header word, one word per bin and a checksum trailer over valid/ready.
// It then pulses hist_clr and returns the histogram to accumulate mode.
module histo_readout #(
  parameter int NUM_BINS = 1024,
  parameter int BIN_W    = 10,
  parameter int DATA_W   = 24,
  parameter int RD_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              hist_rw,
  output logic [BIN_W-1:0]  hist_bin,
  input  logic [DATA_W-1:0] hist_data,
  output logic              hist_clr,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    TAIL = 3'd4,
    CLR  = 3'd5
  } state_t;

  localparam logic [2:0]       LAST_LAT = 3'(RD_LAT - 1);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  state_t      state_r;
  logic [2:0]  lat_cnt_r;
  logic [7:0]  frame_cnt_r;
  logic [31:0] checksum_r;

  logic        accept_s;
  logic [7:0]  bin_byte_s;
  logic [31:0] sum_s;

  // Header word: sync byte, frame number and the bin count of the frame.
  function automatic logic [31:0] hdr_word(input logic [7:0] fc);
    return {8'hA5, fc, 16'(NUM_BINS)};
  endfunction

  // Handshake, bin tag for the data word, and the running checksum that
  // includes the count currently held in the data word (its low 24 bits).
  always_comb begin
    accept_s   = out_valid & out_ready;
    bin_byte_s = 8'(hist_bin);
    sum_s      = checksum_r + {8'h00, out_data[23:0]};
  end

  // Readout sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      lat_cnt_r   <= 3'd0;
      frame_cnt_r <= 8'd0;
      checksum_r  <= 32'd0;
      hist_rw     <= 1'b1;
      hist_bin    <= '0;
      hist_clr    <= 1'b0;
      out_data    <= 32'd0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      hist_clr <= 1'b0;
      // busy is still high during CLR, so a start on the CLR->IDLE edge
      // lands here as well and is flagged instead of starting a frame.
      if (start && busy) begin
        overrun <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r   <= HDR;
            hist_rw   <= 1'b0;
            busy      <= 1'b1;
            overrun   <= 1'b0;
            out_valid <= 1'b1;
            out_sof   <= 1'b1;
            out_data  <= hdr_word(frame_cnt_r);
          end
        end
        HDR: begin
          if (accept_s) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            hist_bin   <= '0;
            lat_cnt_r  <= 3'd0;
            checksum_r <= 32'd0;
            state_r    <= WAIT;
          end
        end
        WAIT: begin
          // hist_data is valid on the last latency cycle; capture it into
          // the output holding register together with the bin tag.
          if (lat_cnt_r == LAST_LAT) begin
            out_data  <= {bin_byte_s, 24'(hist_data)};
            out_valid <= 1'b1;
            state_r   <= SEND;
          end else begin
            lat_cnt_r <= lat_cnt_r + 3'd1;
          end
        end
        SEND: begin
          if (accept_s) begin
            checksum_r <= sum_s;
            if (hist_bin == LAST_BIN) begin
              // valid stays high: the trailer follows directly.
              out_data <= sum_s;
              out_eof  <= 1'b1;
              state_r  <= TAIL;
            end else begin
              hist_bin  <= hist_bin + BIN_W'(1);
              out_valid <= 1'b0;
              lat_cnt_r <= 3'd0;
              state_r   <= WAIT;
            end
          end
        end
        TAIL: begin
          if (accept_s) begin
            out_valid <= 1'b0;
            out_eof   <= 1'b0;
            hist_clr  <= 1'b1;
            state_r   <= CLR;
          end
        end
        CLR: begin
          frame_cnt_r <= frame_cnt_r + 8'd1;
          hist_rw     <= 1'b1;
          hist_bin    <= '0;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
        default: begin
          state_r   <= IDLE;
          hist_rw   <= 1'b1;
          hist_bin  <= '0;
          out_valid <= 1'b0;
          out_sof   <= 1'b0;
          out_eof   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_histo_readout.sv
// tb_histo_readout: self-checking bench for histo_readout.
// Instance A runs the default geometry (1024 bins, read latency 2); instance
// B runs a single bin with latency 1 for the short-frame and frame counter
// wrap scenarios. Expected streams are built from the histogram contents.
module tb_histo_readout;

  localparam int A_N = 1024;
  localparam int A_LAT = 2;
  localparam int B_N = 1;
  localparam int B_LAT = 1;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 1'b0;

  always #5 clk = ~clk;

  // Instance A
  logic        a_start, a_rw, a_clr, a_valid, a_ready, a_sof, a_eof, a_busy, a_ovr;
  logic [9:0]  a_bin;
  logic [23:0] a_hdata;
  logic [31:0] a_data;
  logic [23:0] a_mem [0:A_N-1];
  logic [9:0]  a_dly [1:7];

  // Instance B
  logic        b_start, b_rw, b_clr, b_valid, b_ready, b_sof, b_eof, b_busy, b_ovr;
  logic [9:0]  b_bin;
  logic [23:0] b_hdata;
  logic [31:0] b_data;
  logic [23:0] b_mem0;

  histo_readout #(.NUM_BINS(A_N), .BIN_W(10), .DATA_W(24), .RD_LAT(A_LAT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .hist_rw(a_rw), .hist_bin(a_bin),
    .hist_data(a_hdata), .hist_clr(a_clr), .out_data(a_data), .out_valid(a_valid),
    .out_ready(a_ready), .out_sof(a_sof), .out_eof(a_eof), .busy(a_busy), .overrun(a_ovr)
  );

  histo_readout #(.NUM_BINS(B_N), .BIN_W(10), .DATA_W(24), .RD_LAT(B_LAT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .hist_rw(b_rw), .hist_bin(b_bin),
    .hist_data(b_hdata), .hist_clr(b_clr), .out_data(b_data), .out_valid(b_valid),
    .out_ready(b_ready), .out_sof(b_sof), .out_eof(b_eof), .busy(b_busy), .overrun(b_ovr)
  );

  // Histogram memory model for A: address delay line, data valid RD_LAT cycles
  // after the address changes (latency 1 is a plain asynchronous read).
  always @(posedge clk) begin
    a_dly[1] <= a_bin;
    for (int i = 2; i < 8; i++) a_dly[i] <= a_dly[i-1];
  end
  assign a_hdata = a_mem[(A_LAT == 1) ? a_bin : a_dly[A_LAT-1]];
  assign b_hdata = (b_bin == 10'd0) ? b_mem0 : 24'hBAD000;

  // Stream monitors: record accepted words {sof, eof, data}, count clears and
  // busy cycles, and check hold-while-stalled plus hist_rw == !busy.
  logic [33:0] a_q [$];
  logic [33:0] b_q [$];
  int          a_clr_cnt = 0, a_busy_cyc = 0, b_clr_cnt = 0, b_busy_cyc = 0;
  logic        a_pend = 1'b0;
  logic [33:0] a_held = 34'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_pend <= 1'b0;
    end else begin
      if (a_pend) begin
        checks++;
        assert (a_valid === 1'b1 && {a_sof, a_eof, a_data} === a_held)
          else begin
            errors++;
            $error("FAIL a_hold obs=%b_%h exp=1_%h", a_valid, {a_sof, a_eof, a_data}, a_held);
          end
      end
      checks++;
      assert (a_rw === ~a_busy && b_rw === ~b_busy)
        else begin
          errors++;
          $error("FAIL rw_vs_busy obs=%b%b%b%b exp=rw==!busy", a_rw, a_busy, b_rw, b_busy);
        end
      if (a_valid && a_ready) a_q.push_back({a_sof, a_eof, a_data});
      if (b_valid && b_ready) b_q.push_back({b_sof, b_eof, b_data});
      if (a_clr) a_clr_cnt++;
      if (b_clr) b_clr_cnt++;
      if (a_busy) a_busy_cyc++;
      if (b_busy) b_busy_cyc++;
      a_pend <= a_valid && !a_ready;
      a_held <= {a_sof, a_eof, a_data};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    a_ready = rand_rdy ? ($urandom_range(0, 99) < 30) : 1'b1;
  endtask

  // One full A frame checked against a stream built from a_mem.
  task automatic run_a(input logic [7:0] fc, input int inj_bin, input bit chk_cyc);
    logic [33:0] exp [$];
    logic [31:0] sum;
    logic [7:0]  kb;
    int base, cbase, bbase, n;
    bit inj_done;
    sum = 32'd0;
    inj_done = 1'b0;
    exp.push_back({2'b10, 8'hA5, fc, 16'(A_N)});
    for (int k = 0; k < A_N; k++) begin
      kb = k[7:0];
      exp.push_back({2'b00, kb, a_mem[k]});
      sum = sum + {8'h00, a_mem[k]};
    end
    exp.push_back({2'b01, sum});
    base = a_q.size();
    cbase = a_clr_cnt;
    bbase = a_busy_cyc;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_start_busy", a_busy, 1'b1);
    check("a_hdr_valid", {a_valid, a_sof, a_eof}, 3'b110);
    check("a_hdr_word", a_data, exp[0][31:0]);
    check("a_ovr_cleared", a_ovr, 1'b0);
    check("a_rw_readout", a_rw, 1'b0);
    n = 0;
    while (a_busy && n < 20000) begin
      if (inj_bin >= 0 && !inj_done && a_bin == 10'(inj_bin)) begin
        a_start = 1'b1;
        inj_done = 1'b1;
        tick();
        a_start = 1'b0;
        check("a_inj_ovr", a_ovr, 1'b1);
        check("a_inj_busy", a_busy, 1'b1);
      end else begin
        tick();
      end
      n++;
    end
    check("a_timeout", n < 20000, 1'b1);
    check("a_nwords", a_q.size() - base, exp.size());
    if (a_q.size() - base == exp.size()) begin
      for (int i = 0; i < exp.size(); i++) check($sformatf("a_word%0d", i), a_q[base+i], exp[i]);
    end
    check("a_clr_pulses", a_clr_cnt - cbase, 1);
    if (chk_cyc) check("a_frame_cycles", a_busy_cyc - bbase, 1 + A_N * (A_LAT + 1) + 2);
    check("a_ovr_sticky", a_ovr, (inj_bin >= 0));
    check("a_rw_back", a_rw, 1'b1);
  endtask

  // One B frame (single bin); optionally fire start in the CLR cycle.
  task automatic run_b(input logic [7:0] fc, input bit clr_start);
    logic [33:0] exp [3];
    int base, cbase, bbase, n;
    exp[0] = {2'b10, 8'hA5, fc, 16'(B_N)};
    exp[1] = {2'b00, 8'h00, b_mem0};
    exp[2] = {2'b01, 8'h00, b_mem0};
    base = b_q.size();
    cbase = b_clr_cnt;
    bbase = b_busy_cyc;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_start_busy", b_busy, 1'b1);
    check("b_ovr_cleared", b_ovr, 1'b0);
    n = 0;
    while (b_busy && n < 100) begin
      if (clr_start && b_clr) begin
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        check("b_clr_start_ignored", b_busy, 1'b0);
        check("b_clr_start_ovr", b_ovr, 1'b1);
      end else begin
        tick();
      end
      n++;
    end
    check("b_timeout", n < 100, 1'b1);
    check("b_nwords", b_q.size() - base, 3);
    if (b_q.size() - base == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("b_word%0d_fc%0d", i, fc), b_q[base+i], exp[i]);
    end
    check("b_clr_pulses", b_clr_cnt - cbase, 1);
    check("b_frame_cycles", b_busy_cyc - bbase, 1 + B_N * (B_LAT + 1) + 2);
  endtask

  initial begin
    int n;
    int cbase;
    a_start = 1'b0;
    b_start = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    b_mem0 = 24'h123456;
    for (int k = 0; k < A_N; k++) a_mem[k] = 24'(k);
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_a_stream", {a_valid, a_sof, a_eof, a_data}, 35'd0);
    check("rst_a_ctrl", {a_rw, a_bin, a_clr, a_busy, a_ovr}, {1'b1, 10'd0, 3'b000});
    check("rst_b_ctrl", {b_rw, b_valid, b_busy, b_ovr, b_clr}, 5'b10000);
    rst_n = 1'b1;
    tick();

    // Single bin, latency 1, start in CLR cycle, 257 frames for counter wrap.
    run_b(8'd0, 1'b0);
    run_b(8'd1, 1'b1);
    check("b_idle_after_clr_start", b_busy, 1'b0);
    for (int f = 2; f <= 256; f++) begin
      b_mem0 = 24'($urandom);
      run_b(8'(f), 1'b0);
    end

    // Bins hold their own index; full-rate readout.
    for (int k = 0; k < A_N; k++) a_mem[k] = 24'(k);
    run_a(8'd0, -1, 1'b1);
    check("a_hdr_const", a_q[a_q.size()-A_N-2][31:0], 32'hA5000400);
    check("a_tail_const", a_q[a_q.size()-1][31:0], 32'h0007FE00);

    // Random counts under 30% ready.
    for (int k = 0; k < A_N; k++) a_mem[k] = 24'($urandom);
    rand_rdy = 1'b1;
    run_a(8'd1, -1, 1'b0);
    rand_rdy = 1'b0;
    tick();

    // Start while busy at bin 500.
    for (int k = 0; k < A_N; k++) a_mem[k] = 24'($urandom);
    run_a(8'd2, 500, 1'b1);

    // Reset during SEND of bin 37; the new start also clears overrun.
    cbase = a_clr_cnt;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a_ovr_cleared_by_start", a_ovr, 1'b0);
    check("a_hdr_fc3", a_data, 32'hA5030400);
    n = 0;
    while (!(a_valid && !a_sof && !a_eof && a_bin == 10'd37) && n < 500) begin
      tick();
      n++;
    end
    check("a_reach_bin37", n < 500, 1'b1);
    check("a_send37_word", a_data, {8'd37, a_mem[37]});
    #1;
    rst_n = 1'b0;
    #1;
    check("a_midrst_out", {a_valid, a_eof, a_sof}, 3'b000);
    check("a_midrst_ctrl", {a_rw, a_busy, a_clr}, 3'b100);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("a_midrst_no_clr", a_clr_cnt - cbase, 0);

    // All bins saturated: checksum wraps, and frame number restarts at 0.
    for (int k = 0; k < A_N; k++) a_mem[k] = 24'hFFFFFF;
    run_a(8'd0, -1, 1'b1);
    check("a_wrap_sum", a_q[a_q.size()-1][31:0], 32'hFFFFFC00);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
